// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: MEM-stage request, long-latency result offer and
// the registered register-file write port.
interface wb_arbiter_if;
    // MEM-stage request
    logic        mem_valid;
    logic        mem_wb_en;
    logic        mem_isfloat;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic        mem_stall;

    // Long-latency (div/FP) result handshake
    logic        ll_valid;
    logic        ll_ready;
    logic        ll_isfloat;
    logic [4:0]  ll_rd;
    logic [31:0] ll_result;

    // Register-file write port
    logic        WBctl;
    logic        isfloat_rd;
    logic [4:0]  rd;
    logic [31:0] val3;

    modport master (
        output mem_valid, mem_wb_en, mem_isfloat, mem_rd, mem_is_load, mem_funct3,
               mem_addr_lo, mem_alu_result, mem_load_data,
               ll_valid, ll_isfloat, ll_rd, ll_result,
        input  mem_stall, ll_ready, WBctl, isfloat_rd, rd, val3
    );

    modport slave (
        input  mem_valid, mem_wb_en, mem_isfloat, mem_rd, mem_is_load, mem_funct3,
               mem_addr_lo, mem_alu_result, mem_load_data,
               ll_valid, ll_isfloat, ll_rd, ll_result,
        output mem_stall, ll_ready, WBctl, isfloat_rd, rd, val3
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges MEM-stage writes with long-latency results that
// are buffered in a small in-order FIFO. One register-file write per cycle,
// with WAW ordering against buffered results and a starvation-forced drain.
module wb_arbiter #(
    parameter int unsigned LL_DEPTH   = 2,  // 2 or 4
    parameter int unsigned STARVE_MAX = 4
) (
    input logic        clk,
    input logic        rst,      // synchronous, active-low
    wb_arbiter_if.slave io_bus
);
    localparam int unsigned PW = $clog2(LL_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FullCount   = CW'(LL_DEPTH);
    localparam logic [SW-1:0] StarveLimit = SW'(STARVE_MAX);

    // FIFO storage and control
    logic          r_fifo_isfloat [LL_DEPTH];
    logic [4:0]    r_fifo_rd      [LL_DEPTH];
    logic [31:0]   r_fifo_data    [LL_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;

    // Registered write port
    logic          r_wbctl;
    logic          r_isfloat_rd;
    logic [4:0]    r_rd;
    logic [31:0]   r_val3;

    logic          w_full;
    logic          w_empty;
    logic          w_pipe_req;
    logic          w_ll_req;
    logic          w_ll_ready;
    logic          w_enq;
    logic          w_deq;
    logic          w_waw;
    logic          w_starve;
    logic          w_stall_any;
    logic          w_issue_pipe;
    logic [PW-1:0] w_off;
    logic [31:0]   w_sh_b;
    logic [31:0]   w_sh_h;
    logic [31:0]   w_pipe_val;

    assign w_full  = (r_count == FullCount);
    assign w_empty = (r_count == '0);

    // Integer x0 writes are dropped everywhere, so they never request.
    assign w_pipe_req = io_bus.mem_valid & io_bus.mem_wb_en &
                        ~(~io_bus.mem_isfloat & (io_bus.mem_rd == 5'd0));
    assign w_ll_req   = ~(~io_bus.ll_isfloat & (io_bus.ll_rd == 5'd0));

    assign w_ll_ready = rst & ~w_full;
    assign w_enq      = io_bus.ll_valid & w_ll_ready & w_ll_req;

    // Counter only reaches the limit while full with the pipeline winning.
    assign w_starve     = w_pipe_req & (r_starve == StarveLimit);
    assign w_stall_any  = w_waw | w_starve;
    assign w_issue_pipe = w_pipe_req & ~w_stall_any;
    assign w_deq        = ~w_empty & (w_stall_any | ~w_pipe_req);

    assign io_bus.ll_ready   = w_ll_ready;
    assign io_bus.mem_stall  = rst & io_bus.mem_valid & w_stall_any;
    assign io_bus.WBctl      = r_wbctl;
    assign io_bus.isfloat_rd = r_isfloat_rd;
    assign io_bus.rd         = r_rd;
    assign io_bus.val3       = r_val3;

    // WAW detect: pipeline destination matches any occupied FIFO slot.
    always_comb begin
        w_waw = 1'b0;
        w_off = '0;
        for (int j = 0; j < LL_DEPTH; j++) begin
            w_off = PW'(j) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) &&
                (r_fifo_isfloat[j] == io_bus.mem_isfloat) &&
                (r_fifo_rd[j] == io_bus.mem_rd)) begin
                w_waw = 1'b1;
            end
        end
        w_waw = w_waw & w_pipe_req;
    end

    // Pipeline result: load alignment/extension or the ALU value.
    always_comb begin
        w_sh_b = io_bus.mem_load_data >> {io_bus.mem_addr_lo, 3'b000};
        w_sh_h = io_bus.mem_load_data >> {io_bus.mem_addr_lo[1], 4'b0000};
        w_pipe_val = io_bus.mem_alu_result;
        if (io_bus.mem_is_load) begin
            if (io_bus.mem_isfloat) begin
                w_pipe_val = io_bus.mem_load_data;
            end else begin
                case (io_bus.mem_funct3)
                    3'b000:  w_pipe_val = {{24{w_sh_b[7]}}, w_sh_b[7:0]};
                    3'b001:  w_pipe_val = {{16{w_sh_h[15]}}, w_sh_h[15:0]};
                    3'b100:  w_pipe_val = {24'd0, w_sh_b[7:0]};
                    3'b101:  w_pipe_val = {16'd0, w_sh_h[15:0]};
                    default: w_pipe_val = io_bus.mem_load_data;
                endcase
            end
        end
    end

    // FIFO pointers, fill count and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            for (int j = 0; j < LL_DEPTH; j++) begin
                r_fifo_isfloat[j] <= 1'b0;
                r_fifo_rd[j]      <= 5'd0;
                r_fifo_data[j]    <= 32'd0;
            end
        end else begin
            if (w_enq) begin
                r_fifo_isfloat[r_wr_ptr] <= io_bus.ll_isfloat;
                r_fifo_rd[r_wr_ptr]      <= io_bus.ll_rd;
                r_fifo_data[r_wr_ptr]    <= io_bus.ll_result;
                r_wr_ptr                 <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_deq || !w_full) begin
                r_starve <= '0;
            end else if (r_starve != StarveLimit) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // Registered write port: FIFO head on drain, else the pipeline request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wbctl      <= 1'b0;
            r_isfloat_rd <= 1'b0;
            r_rd         <= 5'd0;
            r_val3       <= 32'd0;
        end else if (w_deq) begin
            r_wbctl      <= 1'b1;
            r_isfloat_rd <= r_fifo_isfloat[r_rd_ptr];
            r_rd         <= r_fifo_rd[r_rd_ptr];
            r_val3       <= r_fifo_data[r_rd_ptr];
        end else if (w_issue_pipe) begin
            r_wbctl      <= 1'b1;
            r_isfloat_rd <= io_bus.mem_isfloat;
            r_rd         <= io_bus.mem_rd;
            r_val3       <= w_pipe_val;
        end else begin
            r_wbctl      <= 1'b0;
            r_isfloat_rd <= 1'b0;
            r_rd         <= 5'd0;
            r_val3       <= 32'd0;
        end
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: LL_DEPTH, default 2, depth of the long-latency result FIFO; legal values are 2 and 4.
REQ-002 Parameter: STARVE_MAX, default 4, number of consecutive full-FIFO cycles before a forced drain.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 mem_valid  in  1  MEM-stage instruction present this cycle.
REQ-006 mem_wb_en  in  1  MEM-stage instruction writes a register.
REQ-007 mem_isfloat  in  1  destination is in the float bank.
REQ-008 mem_rd  in  5  destination register index.
REQ-009 mem_is_load  in  1  result is taken from mem_load_data, not mem_alu_result.
REQ-010 mem_funct3  in  3  load width/sign select.
REQ-011 mem_addr_lo  in  2  byte offset of the load address.
REQ-012 mem_alu_result  in  32  non-load result.
REQ-013 mem_load_data  in  32  raw 32-bit word read from memory.
REQ-014 mem_stall  out  1  holds the MEM stage; combinational.
REQ-015 ll_valid  in  1  long-latency unit (div/FP) result offered.
REQ-016 ll_ready  out  1  arbiter accepts the ll result; a transfer occurs when ll_valid & ll_ready.
REQ-017 ll_isfloat, ll_rd, ll_result  in  1/5/32  ll destination bank, index and data.
REQ-018 WBctl  out  1  register-file write enable; registered.
REQ-019 isfloat_rd  out  1  write targets the float bank; registered.
REQ-020 rd  out  5  write index; registered.
REQ-021 val3  out  32  write data; registered.

Function
REQ-022 Exactly one register-file write is issued per cycle at most; outputs appear 1 cycle after the selected source.
REQ-023 A pipeline write request is defined as mem_valid & mem_wb_en & ~(~mem_isfloat & mem_rd==0).
REQ-024 Integer x0 requests from either source are discarded: never enqueued, never issued, and never cause a stall.
REQ-025 ll_ready = FIFO not full & rst high; the FIFO is in-order with a fill count of 0..LL_DEPTH.
REQ-026 Selection priority: (1) FIFO head if stall_waw or stall_starve; (2) pipeline request; (3) FIFO head; (4) none, giving WBctl=0 next cycle.
REQ-027 stall_waw: asserted when a pipeline request matches the {isfloat, rd} of any valid FIFO entry; the older FIFO entry is then drained first.
REQ-028 stall_starve: asserted when the FIFO has been full for STARVE_MAX consecutive cycles while pipeline requests won arbitration; it forces one FIFO drain and then clears the counter.
REQ-029 mem_stall = mem_valid & (stall_waw | stall_starve); while stalled, the pipeline request is not written.
REQ-030 An enqueue and a dequeue in the same cycle leave the count unchanged; the write and read pointers wrap modulo LL_DEPTH.
REQ-031 The starvation counter increments when the FIFO is full and no dequeue occurs; it resets to 0 on any dequeue or when the FIFO is not full, and saturates at STARVE_MAX.
REQ-032 Load data is shifted by 8*mem_addr_lo for bytes and by 16*mem_addr_lo[1] for halfwords.
REQ-033 Load funct3 decode: 000 LB sign-extend 8; 001 LH sign-extend 16; 100 LBU zero-extend 8; 101 LHU zero-extend 16; all other values pass the full word.
REQ-034 Float loads (mem_isfloat=1) always pass the full word, whatever funct3 is.
REQ-035 Non-load pipeline results pass mem_alu_result unchanged; ll results pass ll_result unchanged.

Reset
REQ-036 When rst=0 at posedge: WBctl=0, isfloat_rd=0, rd=0, val3=0, FIFO emptied, pointers and starvation counter cleared.
REQ-037 While rst=0: ll_ready=0 and mem_stall=0; FIFO entries in flight are dropped, with no partial write.
REQ-038 First write can be issued from the cycle after rst returns to 1.

Verification
REQ-039 LB, addr_lo=3, load_data=0x80FF_1234 -> next cycle WBctl=1, val3=0xFFFF_FF80; LHU, addr_lo=2 -> val3=0x0000_80FF.
REQ-040 ll_valid with rd=5, int, 0x11 while pipeline writes rd=6, 0x22 -> rd6=0x22 written first, then rd5=0x11 on the following idle cycle.
REQ-041 FIFO holds int rd=7; pipeline writes int rd=7 -> mem_stall=1 for 1 cycle, FIFO value written, then the pipeline value; final rd7 = pipeline value.
REQ-042 Float rd=7 in FIFO vs int rd=7 from pipeline -> no stall; the pipeline write proceeds.
REQ-043 FIFO full plus continuous pipeline writes -> after 4 full cycles, mem_stall pulses 1 cycle, one entry drains, and ll_ready returns to 1.
REQ-044 Reset asserted with 2 FIFO entries -> next cycle WBctl=0, ll_ready=0; after release, no stale writes occur and ll_ready=1.
